// File: rtl/text_loader.sv
// Boot-time program loader: turns a little-endian byte stream (word count, then words)
// into mem_text writes from address 0 and holds the RocketTile in reset until done.
module text_loader #(
  parameter int ADDR_W        = 10,
  parameter int RELEASE_DELAY = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   word_count
);

  localparam int          DEPTH   = 2 ** ADDR_W;
  localparam int          DLY_W   = $clog2(RELEASE_DELAY + 1);
  localparam logic [31:0] DEPTH32 = 32'(DEPTH);

  typedef enum logic [2:0] {
    S_HDR,
    S_LOAD,
    S_WAIT,
    S_RUN,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [23:0]         asm_q, asm_d;
  logic [ADDR_W:0]     word_idx_q, word_idx_d;
  logic [ADDR_W:0]     n_q, n_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                core_reset_q, core_reset_d;
  logic                load_done_q, load_done_d;
  logic                load_error_q, load_error_d;
  logic [DLY_W-1:0]    dly_q, dly_d;

  logic                accept;
  logic                last_byte;
  logic [31:0]         word;
  logic [ADDR_W:0]     word_idx_inc;

  // The stream is only open while collecting header or payload bytes.
  assign in_ready     = ((state_q == S_HDR) || (state_q == S_LOAD)) && reset;
  assign accept       = in_valid && in_ready;
  assign last_byte    = accept && (byte_idx_q == 2'd3);
  assign word         = {in_data, asm_q};
  assign word_idx_inc = word_idx_q + (ADDR_W + 1)'(1);

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    asm_d        = asm_q;
    word_idx_d   = word_idx_q;
    n_d          = n_q;
    word_count_d = word_count_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    core_reset_d = core_reset_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;
    dly_d        = dly_q;

    if (accept) begin
      byte_idx_d = byte_idx_q + 2'd1;
      case (byte_idx_q)
        2'd0:    asm_d[7:0]   = in_data;
        2'd1:    asm_d[15:8]  = in_data;
        2'd2:    asm_d[23:16] = in_data;
        default: asm_d        = asm_q;
      endcase
    end

    case (state_q)
      S_HDR: begin
        if (last_byte) begin
          if (word == 32'd0) begin
            state_d = S_WAIT;
            dly_d   = '0;
          end else if (word > DEPTH32) begin
            state_d      = S_ERR;
            load_error_d = 1'b1;
          end else begin
            state_d = S_LOAD;
            n_d     = word[ADDR_W:0];
          end
        end
      end
      S_LOAD: begin
        if (last_byte) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = word_idx_q[ADDR_W-1:0];
          mem_wdata_d = word;
          word_idx_d  = word_idx_inc;
          if (word_count_q < n_q) begin
            word_count_d = word_count_q + (ADDR_W + 1)'(1);
          end
          // Leave on the same edge that issues the final write.
          if (word_idx_inc == n_q) begin
            state_d = S_WAIT;
            dly_d   = '0;
          end
        end
      end
      S_WAIT: begin
        if (dly_q == DLY_W'(RELEASE_DELAY - 1)) begin
          state_d      = S_RUN;
          core_reset_d = 1'b0;
          load_done_d  = 1'b1;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      S_RUN:   state_d = S_RUN;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_HDR;
      byte_idx_q   <= 2'd0;
      word_idx_q   <= '0;
      n_q          <= '0;
      word_count_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
      dly_q        <= '0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      word_idx_q   <= word_idx_d;
      n_q          <= n_d;
      word_count_q <= word_count_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_reset_q <= core_reset_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
      dly_q        <= dly_d;
    end
  end

  // Partial-word bytes are qualified by byte_idx, so the assembly register needs no reset.
  always_ff @(posedge clock) begin
    asm_q <= asm_d;
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_reset = core_reset_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_text_loader.sv
// Self-checking bench for text_loader: randomized byte streams against an in-order
// write-list model with release timing derived from the last write / header byte.
module tb_text_loader;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int RD     = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        in_data = 8'h00;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_reset;
  logic              load_done;
  logic              load_error;
  logic [ADDR_W:0]   word_count;

  text_loader #(.ADDR_W(ADDR_W), .RELEASE_DELAY(RD)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_reset(core_reset), .load_done(load_done), .load_error(load_error),
    .word_count(word_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc_cyc = -1;
  int fall_cyc = -1;
  logic prev_cr = 1'b1;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          lat;
    int          cyc;
  } wr_t;
  wr_t         wlog[$];
  logic [31:0] expw[$];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) last_acc_cyc <= cyc + 1;
  end

  always @(negedge clock) begin
    if (mem_we === 1'b1)
      wlog.push_back('{addr: int'(mem_addr), data: mem_wdata, lat: cyc - last_acc_cyc, cyc: cyc});
    if (core_reset === 1'b0 && prev_cr === 1'b1) fall_cyc <= cyc;
    prev_cr <= core_reset;
  end

  task automatic apply_reset();
    @(negedge clock);
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    int tries = 0;
    while (!ok && tries < 64) begin
      @(negedge clock);
      tries++;
      if (gap > 0 && $urandom_range(99) < gap) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = b;
        ok = (in_ready === 1'b1);
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_byte: byte %02h not accepted within 64 cycles", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic send_stream(input logic [31:0] n_hdr, input int n_words, input int gap);
    logic [31:0] w;
    expw.delete();
    send_word(n_hdr, gap);
    for (int i = 0; i < n_words; i++) begin
      w = $urandom;
      expw.push_back(w);
      send_word(w, gap);
    end
  endtask

  task automatic wait_release(input int bound);
    int n = 0;
    while (core_reset === 1'b1 && n < bound) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (core_reset !== 1'b0) begin
      errors++;
      $display("FAIL release_timeout: core_reset=%b after %0d cycles, required 0", core_reset, bound);
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h5A;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b0 || mem_we !== 1'b0 || core_reset !== 1'b1 || load_done !== 1'b0 ||
        load_error !== 1'b0 || word_count !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b we=%b cr=%b done=%b err=%b cnt=%0d addr=%0d wdata=%h, required 0 0 1 0 0 0 0 0",
               in_ready, mem_we, core_reset, load_done, load_error, word_count, mem_addr, mem_wdata);
    end
    in_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int base;
    apply_reset();
    base = wlog.size();
    expw.delete();
    expw.push_back(32'h0000_0013);
    expw.push_back(32'h0010_0093);
    send_word(32'd2, 0);
    send_word(expw[0], 0);
    send_word(expw[1], 0);
    @(negedge clock);
    in_data = 8'hA5;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready_after_12: in_ready=%b required 0", in_ready);
    end
    wait_release(60);
    in_valid = 1'b0;
    checks++;
    if (wlog.size() - base != 2) begin
      errors++;
      $display("FAIL basic_write_count: got %0d required 2", wlog.size() - base);
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (wlog[base+i].addr != i || wlog[base+i].data !== expw[i] || wlog[base+i].lat != 0) begin
          errors++;
          $display("FAIL basic_write%0d: addr=%0d data=%h lat=%0d required addr=%0d data=%h lat=0",
                   i, wlog[base+i].addr, wlog[base+i].data, wlog[base+i].lat, i, expw[i]);
        end
      end
      checks++;
      if (fall_cyc - wlog[base+1].cyc != RD) begin
        errors++;
        $display("FAIL basic_release_delay: got %0d cycles required %0d", fall_cyc - wlog[base+1].cyc, RD);
      end
    end
    checks++;
    if (load_done !== 1'b1 || word_count !== 11'd2 || load_error !== 1'b0) begin
      errors++;
      $display("FAIL basic_status: done=%b cnt=%0d err=%b required 1 2 0", load_done, word_count, load_error);
    end
  endtask

  task automatic test_zero();
    int base;
    apply_reset();
    base = wlog.size();
    send_word(32'd0, 0);
    @(negedge clock);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_ready: in_ready=%b required 0", in_ready);
    end
    wait_release(60);
    checks++;
    if (fall_cyc - last_acc_cyc != RD) begin
      errors++;
      $display("FAIL zero_release_delay: got %0d cycles required %0d", fall_cyc - last_acc_cyc, RD);
    end
    checks++;
    if (wlog.size() != base || load_done !== 1'b1 || word_count !== '0) begin
      errors++;
      $display("FAIL zero_status: writes=%0d done=%b cnt=%0d required 0 1 0", wlog.size() - base, load_done, word_count);
    end
  endtask

  task automatic test_bad_header();
    int base;
    int bad = 0;
    apply_reset();
    base = wlog.size();
    send_word(32'(DEPTH + 1), 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_data = 8'($urandom);
      if (in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bad_hdr_ready: in_ready high in %0d cycles, required 0", bad);
    end
    checks++;
    if (load_error !== 1'b1 || core_reset !== 1'b1 || load_done !== 1'b0 || wlog.size() != base) begin
      errors++;
      $display("FAIL bad_hdr_status: err=%b cr=%b done=%b writes=%0d required 1 1 0 0",
               load_error, core_reset, load_done, wlog.size() - base);
    end
  endtask

  task automatic test_random_full();
    int base;
    apply_reset();
    base = wlog.size();
    send_stream(32'(DEPTH), DEPTH, 50);
    @(negedge clock);
    in_valid = 1'b0;
    wait_release(100);
    checks++;
    if (wlog.size() - base != DEPTH) begin
      errors++;
      $display("FAIL full_write_count: got %0d required %0d", wlog.size() - base, DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        checks++;
        if (wlog[base+i].addr != i || wlog[base+i].data !== expw[i] || wlog[base+i].lat != 0) begin
          errors++;
          $display("FAIL full_write%0d: addr=%0d data=%h lat=%0d required addr=%0d data=%h lat=0",
                   i, wlog[base+i].addr, wlog[base+i].data, wlog[base+i].lat, i, expw[i]);
        end
      end
      checks++;
      if (fall_cyc - wlog[base+DEPTH-1].cyc != RD) begin
        errors++;
        $display("FAIL full_release_delay: got %0d required %0d", fall_cyc - wlog[base+DEPTH-1].cyc, RD);
      end
    end
    checks++;
    if (word_count !== 11'(DEPTH) || load_done !== 1'b1) begin
      errors++;
      $display("FAIL full_status: cnt=%0d done=%b required %0d 1", word_count, load_done, DEPTH);
    end
  endtask

  task automatic test_reset_mid_load();
    int base;
    apply_reset();
    send_stream(32'd8, 4, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    apply_reset();
    checks++;
    if (word_count !== '0 || core_reset !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_clear: cnt=%0d cr=%b required 0 1", word_count, core_reset);
    end
    base = wlog.size();
    send_stream(32'd3, 3, 0);
    @(negedge clock);
    in_valid = 1'b0;
    wait_release(60);
    checks++;
    if (wlog.size() - base != 3) begin
      errors++;
      $display("FAIL mid_write_count: got %0d required 3", wlog.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wlog[base+i].addr != i || wlog[base+i].data !== expw[i]) begin
          errors++;
          $display("FAIL mid_write%0d: addr=%0d data=%h required addr=%0d data=%h",
                   i, wlog[base+i].addr, wlog[base+i].data, i, expw[i]);
        end
      end
    end
    checks++;
    if (word_count !== 11'd3 || load_done !== 1'b1) begin
      errors++;
      $display("FAIL mid_status: cnt=%0d done=%b required 3 1", word_count, load_done);
    end
  endtask

  task automatic test_run_junk();
    int base;
    int bad = 0;
    base = wlog.size();
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_data = 8'($urandom);
      if (in_ready !== 1'b0) bad++;
    end
    @(negedge clock);
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL run_ready: in_ready high in %0d cycles, required 0", bad);
    end
    checks++;
    if (wlog.size() != base || load_done !== 1'b1 || core_reset !== 1'b0 || word_count !== 11'd3) begin
      errors++;
      $display("FAIL run_status: writes=%0d done=%b cr=%b cnt=%0d required 0 1 0 3",
               wlog.size() - base, load_done, core_reset, word_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_bad_header();
    test_random_full();
    test_reset_mid_load();
    test_run_junk();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
